// File: rtl/mem_dma_pkg.sv
// Shared types and default widths for the mem_dma word-copy engine.
package mem_dma_pkg;

  localparam int MEM_DMA_ADDR_W = 16;
  localparam int MEM_DMA_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_dma.sv
// Single-port memory-to-memory word copy engine (read, then write, per word).
// Optional fill mode compiled in with MEM_DMA_FILL_EN.
//
// state    | meaning
// ST_IDLE  | waiting for start; memory bus parked at zero
// ST_READ  | drive src+index, latch read_data into buffer
// ST_WRITE | drive dst+index with buffer (or fill word), advance index
// ST_DONE  | one-cycle completion pulse
module mem_dma
  import mem_dma_pkg::*;
#(
  parameter int ADDR_W = MEM_DMA_ADDR_W,
  parameter int DATA_W = MEM_DMA_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic              abort,
`ifdef MEM_DMA_FILL_EN
  input  logic              fill,
  input  logic [DATA_W-1:0] fill_value,
`endif
  output logic              MemWrite,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [ADDR_W-1:0] idx_inc;
  logic              fill_mode;
  logic [DATA_W-1:0] fill_word;

`ifdef MEM_DMA_FILL_EN
  logic fill_q, fill_d;
  assign fill_mode = fill_q;
  assign fill_word = fill_value;
`else
  assign fill_mode = 1'b0;
  assign fill_word = '0;
`endif

  assign idx_inc = idx_q + ADDR_W'(1);

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    len_d      = len_q;
    idx_d      = idx_q;
    buf_d      = buf_q;
`ifdef MEM_DMA_FILL_EN
    fill_d     = fill_q;
`endif
    MemWrite   = 1'b0;
    addr       = '0;
    write_data = '0;
    busy       = 1'b0;
    done       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (length != '0) begin
            src_d = src_addr;
            dst_d = dst_addr;
            len_d = length;
            idx_d = '0;
`ifdef MEM_DMA_FILL_EN
            fill_d  = fill;
            state_d = fill ? ST_WRITE : ST_READ;
`else
            state_d = ST_READ;
`endif
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_READ: begin
        busy    = 1'b1;
        addr    = src_q + idx_q;
        buf_d   = read_data;
        state_d = abort ? ST_DONE : ST_WRITE;
      end
      ST_WRITE: begin
        busy       = 1'b1;
        MemWrite   = 1'b1;
        addr       = dst_q + idx_q;
        write_data = fill_mode ? fill_word : buf_q;
        idx_d      = idx_inc;
        // abort still lets this cycle's write land, then stops
        if (abort || idx_inc == len_q) state_d = ST_DONE;
        else if (fill_mode)            state_d = ST_WRITE;
        else                           state_d = ST_READ;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      buf_q   <= '0;
`ifdef MEM_DMA_FILL_EN
      fill_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
`ifdef MEM_DMA_FILL_EN
      fill_q  <= fill_d;
`endif
    end
  end

endmodule
